// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding used by both uart_tx and uart_rx,
// plus the default frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_DATAWIDTH    = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with a trailing edge-detect flop; all flops reset to 1
// so an idle-high line produces no spurious edge when reset is released.
module uart_rx_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic ASYNC_IN,
    output logic SYNC,
    output logic SYNC_D
);

    logic meta;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta   <= 1'b1;
            SYNC   <= 1'b1;
            SYNC_D <= 1'b1;
        end else begin
            meta   <= ASYNC_IN;
            SYNC   <= meta;
            SYNC_D <= SYNC;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-sampled 8N1-style frames, DATARDY/READ handoff to the
// consumer with frame-error pulse and sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EN,
    input  logic                 RX,
    output logic [DATAWIDTH-1:0] DATA,
    output logic                 DATARDY,
    input  logic                 READ,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATAWIDTH - 1);

    uart_state_t          state, state_nxt;
    logic                 rx_s, rx_d;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATAWIDTH-1:0] shreg;
    logic                 half_done, bit_done;
    logic                 cnt_inc, idx_inc, idx_clr, shift_en, word_ok, word_bad;

    uart_rx_sync u_sync (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ASYNC_IN (RX),
        .SYNC     (rx_s),
        .SYNC_D   (rx_d)
    );

    assign half_done = (cnt == HALF_LAST);
    assign bit_done  = (cnt == BIT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Only a genuine high-to-low transition starts a frame, never a line that is already low.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (EN && rx_d && !rx_s)        state_nxt = ST_START;
            ST_START: if (half_done)                  state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (bit_done && idx == IDX_LAST) state_nxt = ST_STOP;
            ST_STOP:  if (bit_done)                   state_nxt = ST_IDLE;
            default:                                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_inc  = 1'b0;
        idx_inc  = 1'b0;
        idx_clr  = 1'b1;
        shift_en = 1'b0;
        word_ok  = 1'b0;
        word_bad = 1'b0;
        case (state)
            ST_START: cnt_inc = !half_done;
            ST_DATA: begin
                idx_clr  = 1'b0;
                cnt_inc  = !bit_done;
                shift_en = bit_done;
                idx_inc  = bit_done;
            end
            ST_STOP: begin
                cnt_inc  = !bit_done;
                word_ok  = bit_done && rx_s;
                word_bad = bit_done && !rx_s;
            end
            default: ;
        endcase
    end

    // Counters reload to zero on every state change instead of wrapping.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_inc ? cnt + CW'(1) : '0;
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + IW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (shift_en) shreg <= DATAWIDTH'({rx_s, shreg} >> 1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DATA      <= '0;
            DATARDY   <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= word_bad;
            if (word_ok) begin
                DATA    <= shreg;
                DATARDY <= 1'b1;
                OVERRUN <= DATARDY && !READ;
            end else if (READ && DATARDY) begin
                DATARDY <= 1'b0;
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule
